// File: rtl/cmos_frame_transmitter_if.sv
// cmos_frame_transmitter_if: camera pins plus frame-store read port of the CMOS emulator
interface cmos_frame_transmitter_if #(
    parameter int ADDR_WIDTH = 17
);
    logic                  enable_i;
    logic [ADDR_WIDTH-1:0] pixel_addr_o;
    logic [15:0]           pixel_data_i;
    logic                  vsync_cmos_o;
    logic                  href_cmos_o;
    logic [7:0]            pixel_data_cmos_o;
    logic                  frame_start_o;
    modport master (
        input  enable_i, pixel_data_i,
        output pixel_addr_o, vsync_cmos_o, href_cmos_o, pixel_data_cmos_o, frame_start_o
    );
    modport slave (
        output enable_i, pixel_data_i,
        input  pixel_addr_o, vsync_cmos_o, href_cmos_o, pixel_data_cmos_o, frame_start_o
    );
endinterface

// File: rtl/cmos_frame_transmitter.sv
// cmos_frame_transmitter: OV7670-style VSYNC/HREF/RGB565 byte source fed from a frame store
module cmos_frame_transmitter #(
    parameter int H_ACTIVE      = 320,
    parameter int V_ACTIVE      = 240,
    parameter int H_BLANK       = 144,
    parameter int VSYNC_LINES   = 3,
    parameter int V_BACK_LINES  = 17,
    parameter int V_FRONT_LINES = 10,
    parameter int ADDR_WIDTH    = $clog2(H_ACTIVE*V_ACTIVE)
) (
    input logic                      pixel_clk_cmos_i,
    input logic                      reset_i,
    cmos_frame_transmitter_if.master bus
);
    localparam int LINE_LEN    = 2*H_ACTIVE + H_BLANK;
    localparam int FRAME_LINES = VSYNC_LINES + V_BACK_LINES + V_ACTIVE + V_FRONT_LINES;
    localparam int HW          = $clog2(LINE_LEN);
    localparam int LW          = $clog2(FRAME_LINES + 1);
    localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_HREF = HW'(2*H_ACTIVE);
    localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(H_ACTIVE*V_ACTIVE - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, BACK, ACTIVE, FRONT} state_t;

    state_t        state, state_n, frame_end;
    logic [HW-1:0] h_cnt, h_n;
    logic [LW-1:0] line_cnt, line_n, line_last;
    logic          line_end, state_done, href_n;
    logic [7:0]    hold;

    always_comb begin
        line_end   = h_cnt == H_LAST;
        line_last  = state == VSYNC  ? LW'(VSYNC_LINES - 1) :
                     state == BACK   ? LW'(V_BACK_LINES - 1) :
                     state == ACTIVE ? LW'(V_ACTIVE - 1) : LW'(V_FRONT_LINES - 1);
        state_done = line_end && line_cnt == line_last;
        frame_end  = bus.enable_i ? VSYNC : IDLE;
        // Zero-length back/front porches are skipped rather than given a dead state
        state_n    = state == IDLE ? (bus.enable_i ? VSYNC : IDLE) :
                     !state_done   ? state :
                     state == VSYNC  ? (V_BACK_LINES == 0 ? ACTIVE : BACK) :
                     state == BACK   ? ACTIVE :
                     state == ACTIVE ? (V_FRONT_LINES == 0 ? frame_end : FRONT) : frame_end;
        h_n        = (state_n != state || state == IDLE || line_end) ? '0 : h_cnt + 1'b1;
        line_n     = state_n != state ? '0 : line_end ? line_cnt + 1'b1 : line_cnt;
        href_n     = state_n == ACTIVE && h_n < H_HREF;
    end

    // Outputs are registered from next-state values so they align with the state they describe
    always_ff @(posedge pixel_clk_cmos_i or posedge reset_i) begin
        if (reset_i) begin
            state                 <= IDLE;
            h_cnt                 <= '0;
            line_cnt              <= '0;
            hold                  <= '0;
            bus.pixel_addr_o      <= '0;
            bus.vsync_cmos_o      <= 1'b0;
            bus.href_cmos_o       <= 1'b0;
            bus.pixel_data_cmos_o <= 8'h00;
            bus.frame_start_o     <= 1'b0;
        end else begin
            state                 <= state_n;
            h_cnt                 <= h_n;
            line_cnt              <= line_n;
            bus.vsync_cmos_o      <= state_n == VSYNC;
            bus.href_cmos_o       <= href_n;
            bus.frame_start_o     <= state_n == VSYNC && state != VSYNC;
            bus.pixel_data_cmos_o <= !href_n ? 8'h00 : h_n[0] ? hold : bus.pixel_data_i[15:8];
            if (href_n && !h_n[0]) begin
                hold             <= bus.pixel_data_i[7:0];
                bus.pixel_addr_o <= bus.pixel_addr_o == A_LAST ? '0 : bus.pixel_addr_o + 1'b1;
            end else if (state_n == IDLE || state_n == VSYNC) begin
                bus.pixel_addr_o <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cmos_frame_transmitter.sv
// tb_cmos_frame_transmitter: randomized scenario bench against a frame-timing reference model
module tb_cmos_frame_transmitter;
    localparam int HA = 4, VA = 3, HB = 2, VS = 1, VB = 1, VF = 1, AW = 4;
    localparam int LL = 2*HA + HB, FL = (VS + VB + VA + VF) * LL, NPIX = HA * VA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_tests = 0, n_fail = 0;
    logic [15:0] mem [16];
    logic [14:0] obs;

    cmos_frame_transmitter_if #(.ADDR_WIDTH(AW)) bus ();

    cmos_frame_transmitter #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LINES(VS),
        .V_BACK_LINES(VB), .V_FRONT_LINES(VF), .ADDR_WIDTH(AW)
    ) dut (
        .pixel_clk_cmos_i(clk),
        .reset_i(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) bus.pixel_data_i <= mem[bus.pixel_addr_o];
    assign obs = {bus.vsync_cmos_o, bus.href_cmos_o, bus.frame_start_o, bus.pixel_data_cmos_o, bus.pixel_addr_o};

    // Expected {vsync, href, frame_start, byte, addr} at cycle n after the vsync rise
    function automatic logic [14:0] exp_out(int n);
        int line = n / LL, h = n % LL, idx, cnt = 0;
        logic vs, hr, fs;
        logic [7:0] by = 8'h00;
        vs  = n < FL && line < VS;
        hr  = n < FL && line >= VS + VB && line < VS + VB + VA && h < 2*HA;
        fs  = n == 0;
        idx = (line - VS - VB) * HA + h / 2;
        if (hr) by = (h % 2 == 0) ? mem[idx][15:8] : mem[idx][7:0];
        for (int k = 0; k < NPIX; k++)
            if ((VS + VB + k / HA) * LL + 2 * (k % HA) <= n) cnt++;
        return {vs, hr, fs, by, 4'(cnt % NPIX)};
    endfunction

    task automatic test_reset();
        int stop;
        rst = 1'b1;
        bus.enable_i = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (obs !== 15'h0) begin n_fail++; $display("FAIL reset_hold got=%h exp=%h", obs, 15'h0); end
        rst = 1'b0;
        @(negedge clk) bus.enable_i = 1'b1;
        @(negedge clk) bus.enable_i = 1'b0;
        stop = $urandom_range(3, FL - 5);
        repeat (stop) @(negedge clk);
        #1 rst = 1'b1;
        #1 n_tests++;
        if (obs !== 15'h0) begin n_fail++; $display("FAIL reset_mid_line n=%0d got=%h exp=%h", stop, obs, 15'h0); end
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== 15'h0) begin n_fail++; $display("FAIL idle_hold i=%0d got=%h exp=%h", i, obs, 15'h0); end
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] bytes[$];
        int vs_cnt = 0, fs_cnt = 0, hr_cnt = 0, rises = 0, first_rise = -1;
        logic prev = 1'b0;
        @(negedge clk) bus.enable_i = 1'b1;
        @(negedge clk) bus.enable_i = 1'b0;
        for (int n = 0; n < FL + 20; n++) begin
            if (n > 0) @(negedge clk);
            n_tests++;
            if (obs !== exp_out(n)) begin n_fail++; $display("FAIL single_frame n=%0d got=%h exp=%h", n, obs, exp_out(n)); end
            if (n == 45 || n == 46) begin
                n_tests++;
                if (bus.pixel_addr_o !== (n == 45 ? 4'd11 : 4'd0))
                    begin n_fail++; $display("FAIL addr_wrap n=%0d got=%0d exp=%0d", n, bus.pixel_addr_o, n == 45 ? 11 : 0); end
            end
            vs_cnt += int'(bus.vsync_cmos_o);
            fs_cnt += int'(bus.frame_start_o);
            hr_cnt += int'(bus.href_cmos_o);
            if (bus.href_cmos_o && !prev) begin rises++; if (first_rise < 0) first_rise = n; end
            prev = bus.href_cmos_o;
            if (bus.href_cmos_o) bytes.push_back(bus.pixel_data_cmos_o);
        end
        n_tests += 5;
        if (vs_cnt != 10) begin n_fail++; $display("FAIL vsync_len got=%0d exp=10", vs_cnt); end
        if (fs_cnt != 1) begin n_fail++; $display("FAIL frame_start_len got=%0d exp=1", fs_cnt); end
        if (rises != 3) begin n_fail++; $display("FAIL href_pulses got=%0d exp=3", rises); end
        if (hr_cnt != 24) begin n_fail++; $display("FAIL href_cycles got=%0d exp=24", hr_cnt); end
        if (first_rise != 20) begin n_fail++; $display("FAIL href_first_rise got=%0d exp=20", first_rise); end
        n_tests++;
        if (bytes.size() != 24) begin n_fail++; $display("FAIL byte_count got=%0d exp=24", bytes.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (bytes[i] !== (i % 2 == 0 ? 8'hA0 : 8'(i / 2)))
                    begin n_fail++; $display("FAIL line0_byte i=%0d got=%h exp=%h", i, bytes[i], i % 2 == 0 ? 8'hA0 : 8'(i / 2)); end
            end
            n_tests++;
            if ({bytes[22], bytes[23]} !== 16'hA00B) begin n_fail++; $display("FAIL line2_end got=%h%h exp=a00b", bytes[22], bytes[23]); end
        end
    endtask

    task automatic test_continuous();
        logic [7:0] first[$], rest[$];
        int rises[$];
        int bad = 0;
        logic prev = 1'b0;
        repeat ($urandom_range(1, 7)) @(negedge clk);
        bus.enable_i = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 3*FL + 20; n++) begin
            if (n > 0) @(negedge clk);
            if (n == 2*FL + 30) bus.enable_i = 1'b0;
            n_tests++;
            if (obs !== exp_out(n < 3*FL ? n % FL : FL))
                begin n_fail++; $display("FAIL continuous n=%0d got=%h exp=%h", n, obs, exp_out(n < 3*FL ? n % FL : FL)); end
            if (bus.vsync_cmos_o && !prev) rises.push_back(n);
            prev = bus.vsync_cmos_o;
            if (bus.href_cmos_o) begin
                if (n < FL) first.push_back(bus.pixel_data_cmos_o);
                else rest.push_back(bus.pixel_data_cmos_o);
            end
        end
        n_tests++;
        if (rises.size() != 3) begin n_fail++; $display("FAIL vsync_rises got=%0d exp=3", rises.size()); end
        else begin
            n_tests++;
            if (rises[1] - rises[0] != FL || rises[2] - rises[1] != FL)
                begin n_fail++; $display("FAIL vsync_period got=%0d,%0d exp=%0d", rises[1] - rises[0], rises[2] - rises[1], FL); end
        end
        n_tests++;
        if (first.size() == 0 || rest.size() != 2 * first.size()) bad = 1;
        else foreach (rest[i]) if (rest[i] !== first[i % first.size()]) bad++;
        if (bad != 0) begin n_fail++; $display("FAIL frame_repeat got=%0d differing bytes exp=0", bad); end
    endtask

    task automatic test_mid_frame_disable();
        int drop = $urandom_range(30, 39), rises = 0;
        logic prev = 1'b0;
        repeat ($urandom_range(1, 9)) @(negedge clk);
        bus.enable_i = 1'b1;
        @(negedge clk);
        for (int n = 0; n < FL + 40; n++) begin
            if (n > 0) @(negedge clk);
            if (n == drop) bus.enable_i = 1'b0;
            n_tests++;
            if (obs !== exp_out(n)) begin n_fail++; $display("FAIL mid_disable n=%0d got=%h exp=%h", n, obs, exp_out(n)); end
            if (bus.vsync_cmos_o && !prev) rises++;
            prev = bus.vsync_cmos_o;
        end
        n_tests++;
        if (rises != 1) begin n_fail++; $display("FAIL mid_disable_vsyncs got=%0d exp=1", rises); end
    endtask

    task automatic test_reset_active();
        bus.enable_i = 1'b1;
        @(negedge clk);
        for (int n = 0; n <= 25; n++) begin
            if (n > 0) @(negedge clk);
            n_tests++;
            if (obs !== exp_out(n)) begin n_fail++; $display("FAIL pre_reset n=%0d got=%h exp=%h", n, obs, exp_out(n)); end
        end
        #1 rst = 1'b1;
        #1 n_tests += 3;
        if (bus.href_cmos_o !== 1'b0) begin n_fail++; $display("FAIL reset_href got=%b exp=0", bus.href_cmos_o); end
        if (bus.pixel_data_cmos_o !== 8'h00) begin n_fail++; $display("FAIL reset_byte got=%h exp=00", bus.pixel_data_cmos_o); end
        if (bus.pixel_addr_o !== 4'd0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", bus.pixel_addr_o); end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        for (int n = 0; n < FL + 10; n++) begin
            if (n > 0) @(negedge clk);
            if (n == FL - 5) bus.enable_i = 1'b0;
            n_tests++;
            if (obs !== exp_out(n)) begin n_fail++; $display("FAIL post_reset n=%0d got=%h exp=%h", n, obs, exp_out(n)); end
        end
    endtask

    task automatic test_random_image();
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        repeat ($urandom_range(2, 9)) @(negedge clk);
        bus.enable_i = 1'b1;
        @(negedge clk) bus.enable_i = 1'b0;
        for (int n = 0; n < FL + 5; n++) begin
            if (n > 0) @(negedge clk);
            n_tests++;
            if (obs !== exp_out(n)) begin n_fail++; $display("FAIL random_image n=%0d got=%h exp=%h", n, obs, exp_out(n)); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'hA000 + 16'(i);
        bus.enable_i = 1'b0;
        test_reset();
        test_single_frame();
        test_continuous();
        test_mid_frame_disable();
        test_reset_active();
        test_random_image();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
